// File: rtl/test_read_ctrl_pkg.sv
// Shared types and constants for the block read-back controller.
// Holds the FSM state encoding, the default expected ciphertext and the block geometry.
package test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    GAP,
    DONE
  } state_t;

  localparam int BYTES_PER_BLK = 16;
  localparam logic [127:0] DEFAULT_EXP = 128'haa0024fdd891e228677801fe62048ccf;

  // Byte 0 of a block lives in the most significant byte lane.
  function automatic logic [7:0] blk_byte(input logic [127:0] blk, input logic [3:0] idx);
    logic [127:0] shifted;
    shifted = blk << {idx, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/test_read_ctrl_if.sv
// Bus between the read controller and its host/chip side.
// The master modport is the controller; the slave modport is the chip plus host.
interface test_read_ctrl_if;

  logic         start;
  logic         data_ready;
  logic [7:0]   read_data;
  logic [127:0] exp_block;
  logic         read_en;
  logic         busy;
  logic         done;
  logic         pass;
  logic         timeout;
  logic [7:0]   blk_cnt;
  logic [7:0]   err_cnt;
  logic         led1;
  logic         led2;
  logic         led3;

  modport master (
    input  start, data_ready, read_data, exp_block,
    output read_en, busy, done, pass, timeout, blk_cnt, err_cnt, led1, led2, led3
  );

  modport slave (
    output start, data_ready, read_data, exp_block,
    input  read_en, busy, done, pass, timeout, blk_cnt, err_cnt, led1, led2, led3
  );

endinterface

// File: rtl/test_read_ctrl_blk_checker.sv
// Byte comparator for the read controller: tracks the byte index within a block,
// accumulates a per-block mismatch flag and counts completed and failing blocks.
module test_blk_checker
  import test_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         capture,
  input  logic [7:0]   read_data,
  input  logic [127:0] exp_block,
  output logic         last_byte,
  output logic [7:0]   blk_cnt,
  output logic [7:0]   err_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_BLK - 1);

  logic [3:0] idx;
  logic       blk_bad;
  logic       byte_bad;

  assign byte_bad  = (read_data != blk_byte(exp_block, idx));
  assign last_byte = (idx == LAST_IDX);

  // A block counts as failing if any of its bytes mismatched; the error count sticks at 255.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx     <= '0;
      blk_bad <= 1'b0;
      blk_cnt <= '0;
      err_cnt <= '0;
    end else if (capture) begin
      if (last_byte) begin
        blk_cnt <= blk_cnt + 8'd1;
        if ((blk_bad || byte_bad) && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
        blk_bad <= 1'b0;
        idx     <= '0;
      end else begin
        blk_bad <= blk_bad | byte_bad;
        idx     <= idx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/test_read_ctrl.sv
// Read-back controller: strobes bytes out of the chip, compares each against the
// expected ciphertext block and reports pass/fail, block counts and timeouts.
module test_read_ctrl
  import test_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  test_read_ctrl_if.master  bus
);

  localparam logic [7:0]  BLK_LAST  = 8'(NUM_BLOCKS - 1);
  localparam logic [3:0]  GAP_LAST  = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] wait_cnt;
  logic [3:0]  gap_cnt;
  logic        timeout_q;
  logic        led1_q;
  logic        run_start;
  logic        capture;
  logic        last_byte;
  logic        wait_expired;
  logic        done_w;
  logic        pass_w;
  logic [7:0]  blk_cnt;
  logic [7:0]  err_cnt;

  assign run_start    = bus.start && ((state == IDLE) || (state == DONE));
  assign capture      = (state == CAPTURE);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  test_blk_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .clear     (run_start),
    .capture   (capture),
    .read_data (bus.read_data),
    .exp_block (bus.exp_block),
    .last_byte (last_byte),
    .blk_cnt   (blk_cnt),
    .err_cnt   (err_cnt)
  );

  // read_en is decoded from ISSUE so it lasts exactly the cycle data_ready is seen,
  // and the mandatory CAPTURE cycle that follows keeps strobes at least 2 cycles apart.
  always_comb begin
    next_state  = state;
    bus.read_en = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) next_state = ISSUE;
      end
      ISSUE: begin
        if (bus.data_ready) begin
          bus.read_en = 1'b1;
          next_state  = CAPTURE;
        end else if (wait_expired) begin
          next_state = DONE;
        end
      end
      CAPTURE: begin
        if (last_byte && (blk_cnt == BLK_LAST)) next_state = DONE;
        else if (GAP_CYCLES > 0)                next_state = GAP;
        else                                    next_state = ISSUE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) next_state = ISSUE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The wait counter restarts on every entry into ISSUE, so the timeout is per byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      timeout_q <= 1'b0;
      led1_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (run_start) begin
        timeout_q <= 1'b0;
        led1_q    <= 1'b0;
      end
      if ((state == ISSUE) && !bus.data_ready && wait_expired) timeout_q <= 1'b1;
      if (capture) led1_q <= 1'b1;
      if ((next_state == ISSUE) && (state != ISSUE)) wait_cnt <= '0;
      else if (state == ISSUE)                       wait_cnt <= wait_cnt + 16'd1;
      if (state == GAP) gap_cnt <= gap_cnt + 4'd1;
      else              gap_cnt <= '0;
    end
  end

  assign done_w      = (state == DONE);
  assign pass_w      = done_w && (err_cnt == 8'd0) && !timeout_q;
  assign bus.busy    = (state == ISSUE) || (state == CAPTURE) || (state == GAP);
  assign bus.done    = done_w;
  assign bus.pass    = pass_w;
  assign bus.timeout = timeout_q;
  assign bus.blk_cnt = blk_cnt;
  assign bus.err_cnt = err_cnt;
  assign bus.led1    = led1_q;
  assign bus.led2    = pass_w;
  assign bus.led3    = done_w;

endmodule

// File: tb/tb_test_read_ctrl.sv
// Self-checking bench for test_read_ctrl: a chip model feeds bytes, runs are scored
// against a queue of expected outcomes computed from the block contents and stall budget.
module tb_test_read_ctrl;
  import test_pkg::*;

  localparam int NB  = 4;
  localparam int GAP = 2;
  localparam int TMO = 255;

  typedef struct {
    int blk;
    int err;
    bit pass;
    bit tmo;
    bit led1;
    int pulses;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  test_read_ctrl_if a_if ();
  test_read_ctrl_if b_if ();

  test_read_ctrl #(.NUM_BLOCKS(NB), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  test_read_ctrl #(.NUM_BLOCKS(NB), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  result_t    exp_q[$];
  logic [7:0] chip_q[$];
  int compared    = 0;
  int mismatched  = 0;
  int cyc         = 0;
  int pulses      = 0;
  int last_pulse  = 0;
  int ready_limit = 0;
  bit stalls      = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int i);
    logic [127:0] t;
    t = blk >> (8 * (15 - i));
    return t[7:0];
  endfunction

  task automatic check_output(input string name, input longint actual, input longint required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic report_fail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: actual=expired required=event", name);
  endtask

  // Chip model: answers each read_en with the next queued byte one cycle later.
  initial begin
    logic       fire;
    logic [7:0] b;
    a_if.data_ready = 1'b0;
    a_if.read_data  = 8'h00;
    b = 8'h00;
    forever begin
      @(negedge clk);
      fire = a_if.read_en;
      if (fire) begin
        if (pulses > 0) begin
          if (stalls) check_output("read_en spacing min", longint'((cyc - last_pulse) >= GAP + 2), 1);
          else        check_output("read_en spacing", cyc - last_pulse, GAP + 2);
        end
        last_pulse = cyc;
        pulses++;
        b = (chip_q.size() > 0) ? chip_q.pop_front() : 8'h00;
      end
      @(posedge clk);
      #1;
      if (fire) a_if.read_data = b;
      a_if.data_ready = (pulses < ready_limit) && (!stalls || ($urandom_range(0, 3) != 0));
    end
  end

  // Monitor: every rising done is matched against the oldest expected outcome.
  initial begin
    result_t e;
    logic    prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_if.done && !prev) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected done");
        end else begin
          e = exp_q.pop_front();
          check_output("blk_cnt", a_if.blk_cnt, e.blk);
          check_output("err_cnt", a_if.err_cnt, e.err);
          check_output("pass", a_if.pass, e.pass);
          check_output("led2", a_if.led2, e.pass);
          check_output("timeout", a_if.timeout, e.tmo);
          check_output("led1", a_if.led1, e.led1);
          check_output("led3", a_if.led3, 1);
          check_output("busy at done", a_if.busy, 0);
          check_output("read_en pulses", pulses, e.pulses);
          if (e.tmo && e.pulses > 0)
            check_output("timeout latency", cyc - last_pulse, TMO + GAP + 2);
        end
      end
      prev = a_if.done;
    end
  end

  task automatic apply_stimulus(input logic [127:0] exp, input int cblk, input int cbyte,
                                input logic [7:0] cval, input bit rnd_err, input int limit,
                                input bit stall, input bit expect_done);
    result_t    r;
    bit         bad[NB];
    logic [7:0] bv;
    logic [7:0] good;
    int         nbytes;
    chip_q.delete();
    for (int blk = 0; blk < NB; blk++) begin
      bad[blk] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        good = get_byte(exp, i);
        bv   = good;
        if (blk == cblk && i == cbyte) bv = cval;
        if (rnd_err && $urandom_range(0, 19) == 0) bv = good ^ 8'($urandom_range(1, 255));
        chip_q.push_back(bv);
        if (bv != good) bad[blk] = 1'b1;
      end
    end
    nbytes   = (limit < NB * 16) ? limit : NB * 16;
    r.pulses = nbytes;
    r.blk    = nbytes / 16;
    r.tmo    = (limit < NB * 16);
    r.err    = 0;
    for (int blk = 0; blk < r.blk; blk++) if (bad[blk]) r.err++;
    r.pass   = !r.tmo && (r.err == 0);
    r.led1   = (nbytes > 0);
    if (expect_done) exp_q.push_back(r);
    @(posedge clk);
    #1;
    a_if.exp_block = exp;
    ready_limit    = limit;
    stalls         = stall;
    pulses         = 0;
    a_if.start     = 1'b1;
    @(posedge clk);
    #1;
    a_if.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (a_if.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) report_fail({tag, " done wait"});
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " read_en"}, a_if.read_en, 0);
    check_output({tag, " busy"}, a_if.busy, 0);
    check_output({tag, " done"}, a_if.done, 0);
    check_output({tag, " pass"}, a_if.pass, 0);
    check_output({tag, " timeout"}, a_if.timeout, 0);
    check_output({tag, " blk_cnt"}, a_if.blk_cnt, 0);
    check_output({tag, " err_cnt"}, a_if.err_cnt, 0);
    check_output({tag, " leds"}, {a_if.led1, a_if.led2, a_if.led3}, 0);
  endtask

  // Zero-gap instance: strobes must land exactly every other cycle.
  task automatic run_gap0();
    int         n;
    int         last;
    bit         seen;
    logic [7:0] b;
    n    = 0;
    last = 0;
    seen = 1'b0;
    @(posedge clk);
    #1 b_if.start = 1'b1;
    @(posedge clk);
    #1 b_if.start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (b_if.done) begin
        seen = 1'b1;
        break;
      end
      if (b_if.read_en) begin
        if (n > 0) check_output("gap0 read_en spacing", cyc - last, 2);
        last = cyc;
        b    = get_byte(DEFAULT_EXP, n % 16);
        n++;
        @(posedge clk);
        #1 b_if.read_data = b;
      end
    end
    if (!seen) report_fail("gap0 done wait");
    check_output("gap0 pulses", n, NB * 16);
    check_output("gap0 blk_cnt", b_if.blk_cnt, NB);
    check_output("gap0 pass", b_if.pass, 1);
  endtask

  initial begin
    bit reached;
    a_if.start      = 1'b0;
    a_if.exp_block  = DEFAULT_EXP;
    b_if.start      = 1'b0;
    b_if.exp_block  = DEFAULT_EXP;
    b_if.data_ready = 1'b1;
    b_if.read_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] clean run with default block");
    apply_stimulus(DEFAULT_EXP, -1, -1, 8'h00, 1'b0, 1000, 1'b0, 1'b1);
    wait_done("clean");

    $display("[TB] single corrupted byte in last block");
    apply_stimulus(DEFAULT_EXP, 3, 13, 8'h05, 1'b0, 1000, 1'b0, 1'b1);
    wait_done("corrupt");

    $display("[TB] chip stops answering after byte 5");
    apply_stimulus(DEFAULT_EXP, -1, -1, 8'h00, 1'b0, 6, 1'b0, 1'b1);
    wait_done("timeout");

    $display("[TB] reset during block 2 byte 9");
    apply_stimulus(DEFAULT_EXP, -1, -1, 8'h00, 1'b0, 1000, 1'b0, 1'b0);
    reached = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (pulses >= 2 * 16 + 10) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) report_fail("mid-run byte wait");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("mid-run reset");
    rst = 1'b0;
    apply_stimulus(DEFAULT_EXP, -1, -1, 8'h00, 1'b0, 1000, 1'b0, 1'b1);
    wait_done("after reset");

    $display("[TB] start re-pulsed while busy");
    apply_stimulus(DEFAULT_EXP, 1, 0, 8'h00, 1'b0, 1000, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      repeat (20) @(posedge clk);
      #1 a_if.start = 1'b1;
      @(posedge clk);
      #1 a_if.start = 1'b0;
    end
    wait_done("restart ignored");

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, -1, -1, 8'h00, 1'b1,
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB * 16 - 1)) : 1000,
                     1'b1, 1'b1);
      wait_done("random");
    end

    $display("[TB] zero-gap instance");
    run_gap0();

    repeat (3) @(negedge clk);
    check_output("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/test_read_ctrl.md
TEST_READ_CTRL -- requirements
Module: test_read_ctrl

Interface
REQ-001 Parameter NUM_BLOCKS, default 4: number of 16-byte blocks read per run (1..255).
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted after each byte capture (0..15).
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for data_ready per byte (1..65535).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle run request; honoured only in IDLE or DONE.
REQ-007 data_ready  in  1  chip has an output byte available.
REQ-008 read_data  in  8  chip output byte, valid the cycle after read_en.
REQ-009 exp_block  in  128  expected ciphertext, byte 0 = bits [127:120], held stable during a run.
REQ-010 read_en  out  1  one-cycle byte read strobe to chip.
REQ-011 busy  out  1  run in progress.
REQ-012 done  out  1  run finished; held until next start or rst.
REQ-013 pass  out  1  valid when done: err_cnt==0 and no timeout.
REQ-014 timeout  out  1  a byte wait exceeded TIMEOUT.
REQ-015 blk_cnt  out  8  completed blocks this run.
REQ-016 err_cnt  out  8  blocks with at least one mismatching byte; saturates at 255.
REQ-017 led1/led2/led3  out  1 each  led1 = first byte captured this run, led2 = pass, led3 = done.

Function
REQ-018 FSM states: IDLE, ISSUE, CAPTURE, GAP, DONE.
REQ-019 IDLE/DONE + start -> ISSUE; clear blk_cnt, err_cnt, timeout, byte index, wait counter, led1, block-mismatch flag; done <= 0, busy <= 1.
REQ-020 ISSUE: if data_ready=1, read_en=1 for exactly that cycle and -> CAPTURE; else wait counter increments.
REQ-021 ISSUE: wait counter reaching TIMEOUT with data_ready=0 -> DONE, timeout <= 1, read_en never asserted.
REQ-022 CAPTURE: sample read_data (one cycle after read_en), compare with exp_block byte[idx], OR mismatch into block flag, led1 <= 1.
REQ-023 CAPTURE at idx=15: blk_cnt += 1; err_cnt += 1 if flag set (saturating at 255); clear flag; idx <= 0.
REQ-024 CAPTURE otherwise: idx += 1.
REQ-025 After CAPTURE: -> GAP if GAP_CYCLES>0, else -> ISSUE; after the final block -> DONE directly.
REQ-026 GAP: counts GAP_CYCLES cycles, then -> ISSUE; wait counter cleared on every ISSUE entry.
REQ-027 DONE: busy=0, done=1, pass and led2 = (err_cnt==0 && !timeout), led3=1; counters hold.
REQ-028 start while busy is ignored; start in DONE restarts per REQ-019.
REQ-029 read_en never asserts on consecutive cycles; minimum spacing 2 cycles.
REQ-030 data_ready is sampled only in ISSUE.

Reset
REQ-031 rst=1 forces IDLE at the next edge and overrides start and every other input.
REQ-032 Reset values: read_en, busy, done, pass, timeout, leds = 0; blk_cnt, err_cnt, idx, counters = 0.
REQ-033 Reset mid-run drops read_en at the same edge, and any partial block is discarded.

Structure
REQ-034 Shared package test_pkg holds the state enum, DEFAULT_EXP = 128'haa0024fdd891e228677801fe62048ccf, and BYTES_PER_BLK = 16.
REQ-035 One sub-module, test_blk_checker, holds the byte index, the compare logic, the mismatch flag and the block/error counters; the top holds the FSM, wait counter and gap counter.

Verification
REQ-036 exp_block=DEFAULT_EXP, data_ready=1, chip returns matching bytes, NUM_BLOCKS=4 -> 64 read_en pulses, blk_cnt=4, err_cnt=0, pass=1, led3=1.
REQ-037 Same run, but byte 13 of block 3 is 8'h05 instead of 8'h04 -> blk_cnt=4, err_cnt=1, pass=0, led2=0.
REQ-038 data_ready held 0 after byte 5 -> timeout=1 after 255 cycles, done=1, pass=0, blk_cnt=0.
REQ-039 rst pulsed on byte 9 of block 2 -> next cycle all outputs 0, FSM in IDLE; a new start gives a clean 4-block pass.
REQ-040 start re-pulsed while busy -> no effect, blk_cnt continues; GAP_CYCLES=0 -> read_en spacing is exactly 2 cycles.
